// File: rtl/dsm_pkg.sv
// Shared types and constants for the MASH 1-1 delta-sigma modulator.
// Output sample type, control state enum and dither LFSR parameters.
package dsm_pkg;

  typedef logic signed [2:0] dsm_out_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } dsm_state_t;

  // x^23 + x^18 + 1, maximal length
  localparam int LFSR_W     = 23;
  localparam int LFSR_TAP_A = 22;
  localparam int LFSR_TAP_B = 17;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 23'd1;

endpackage

// File: rtl/dsm_acc_stage.sv
// First-order error-feedback accumulator: residue register plus carry out.
// Ports: clk, rst_n, en_i, add_i, cin_i -> carry_o, res_o (next residue).
module dsm_acc_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] add_i,
  input  logic             cin_i,
  output logic             carry_o,
  output logic [WIDTH-1:0] res_o
);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH:0]   sum;

  assign sum = {1'b0, acc_q}
             + {1'b0, add_i}
             + (WIDTH+1)'(cin_i);

  assign carry_o = sum[WIDTH];
  assign res_o   = sum[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= res_o;
    end
  end

endmodule

// File: rtl/mash11_dsm.sv
// MASH 1-1 delta-sigma DAC modulator with ZOH input hold and AXIS input.
// Ports: aclk, arst_n, s_axis_data_*, m_axis_data_*, underrun. Option: DSM_DITHER_EN.
module mash11_dsm
  import dsm_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OSR   = 64
) (
  input  logic                    aclk,
  input  logic                    arst_n,
  input  logic signed [WIDTH-1:0] s_axis_data_tdata,
  input  logic                    s_axis_data_tvalid,
  output logic                    s_axis_data_tready,
  output dsm_out_t                m_axis_data_tdata,
  output logic                    m_axis_data_tvalid,
  output logic                    underrun
);

  localparam int CW = $clog2(OSR);
  localparam logic [CW-1:0] LAST = CW'(OSR - 1);
  localparam logic [WIDTH-1:0] MID =
    {1'b1, {(WIDTH-1){1'b0}}};

  dsm_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             under_q, under_d;
  logic             c2z_q;
  dsm_out_t         y_q, y_d;
  logic             vld_q;

  logic             run;
  logic             at_bnd;
  logic             xfer;
  logic             dith;
  logic [WIDTH-1:0] u;
  logic             c1, c2;
  logic [WIDTH-1:0] acc1_d, acc2_d;
  logic             unused_res2;

  assign run    = (state_q == RUN);
  assign at_bnd = (cnt_q == LAST);
  assign xfer   = s_axis_data_tvalid
               && s_axis_data_tready;

  assign s_axis_data_tready = !run || at_bnd;
  assign m_axis_data_tdata  = y_q;
  assign m_axis_data_tvalid = vld_q;
  assign underrun           = under_q;

  // Offset binary: signed full scale maps onto 0..2^WIDTH-1
  assign u = hold_q ^ MID;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    under_d = under_q;
    if (xfer) hold_d = s_axis_data_tdata;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        cnt_d = at_bnd ? '0 : cnt_q + 1'b1;
        if (at_bnd && !s_axis_data_tvalid)
          under_d = 1'b1;
      end
    endcase
  end

`ifdef DSM_DITHER_EN
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[LFSR_W-2:0],
                   lfsr_q[LFSR_TAP_A]
                 ^ lfsr_q[LFSR_TAP_B]};
  assign dith = lfsr_q[0];

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      lfsr_q <= LFSR_SEED;
    end else if (run) begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign dith = 1'b0;
`endif

  dsm_acc_stage #(.WIDTH(WIDTH)) u_st1 (
    .clk     (aclk),
    .rst_n   (arst_n),
    .en_i    (run),
    .add_i   (u),
    .cin_i   (dith),
    .carry_o (c1),
    .res_o   (acc1_d)
  );

  // Second stage integrates the first stage's new residue
  dsm_acc_stage #(.WIDTH(WIDTH)) u_st2 (
    .clk     (aclk),
    .rst_n   (arst_n),
    .en_i    (run),
    .add_i   (acc1_d),
    .cin_i   (1'b0),
    .carry_o (c2),
    .res_o   (acc2_d)
  );

  assign unused_res2 = ^acc2_d;

  // Noise cancellation: c1 + (1 - z^-1) c2
  always_comb begin
    y_d = dsm_out_t'({2'b00, c1})
        + dsm_out_t'({2'b00, c2})
        - dsm_out_t'({2'b00, c2z_q});
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      under_q <= 1'b0;
      c2z_q   <= 1'b0;
      y_q     <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      under_q <= under_d;
      if (run) begin
        c2z_q <= c2;
        y_q   <= y_d;
        vld_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mash11_dsm.sv
// Self-checking bench for mash11_dsm: random and directed stimulus,
// arithmetic reference model feeding a scoreboard queue.
module tb_mash11_dsm;

  localparam int W   = 16;
  localparam int OSR = 64;
  localparam longint MOD = 65536;

  logic                aclk = 1'b0;
  logic                arst_n;
  logic signed [W-1:0] s_tdata;
  logic                s_tvalid;
  logic                s_tready;
  logic signed [2:0]   m_tdata;
  logic                m_tvalid;
  logic                under;

  int n_chk  = 0;
  int n_fail = 0;

  int exp_q[$];

  bit     m_run, m_vld, m_under;
  int     m_phase, m_hold, m_c2z;
  longint m_acc1, m_acc2;

  always #5 aclk = ~aclk;

  mash11_dsm #(.WIDTH(W), .OSR(OSR)) dut (
    .aclk               (aclk),
    .arst_n             (arst_n),
    .s_axis_data_tdata  (s_tdata),
    .s_axis_data_tvalid (s_tvalid),
    .s_axis_data_tready (s_tready),
    .m_axis_data_tdata  (m_tdata),
    .m_axis_data_tvalid (m_tvalid),
    .underrun           (under)
  );

  task automatic check(input string nm,
                       input int got,
                       input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d",
               nm, got, want);
    end
  endtask

  task automatic model_reset();
    m_run   = 0;
    m_vld   = 0;
    m_under = 0;
    m_phase = 0;
    m_hold  = 0;
    m_c2z   = 0;
    m_acc1  = 0;
    m_acc2  = 0;
  endtask

  // One modulator edge, from the rules: offset-binary input,
  // two modular accumulators, y = c1 + c2 - previous c2.
  task automatic model_edge(input bit v, input int d);
    longint u, s1, s2;
    int c1, c2;
    if (!m_run) begin
      if (v) begin
        m_hold  = d;
        m_run   = 1;
        m_phase = 0;
      end
    end else begin
      u  = longint'(m_hold) + 32768;
      s1 = m_acc1 + u;
      c1 = (s1 >= MOD) ? 1 : 0;
      m_acc1 = s1 % MOD;
      s2 = m_acc2 + m_acc1;
      c2 = (s2 >= MOD) ? 1 : 0;
      m_acc2 = s2 % MOD;
      exp_q.push_back(c1 + c2 - m_c2z);
      m_c2z = c2;
      m_vld = 1;
      if (m_phase == OSR - 1) begin
        if (v) m_hold = d;
        else   m_under = 1;
      end
      m_phase = (m_phase + 1) % OSR;
    end
  endtask

  task automatic cycle(input bit v, input int d);
    bit rdy;
    @(negedge aclk);
    rdy = !m_run || (m_phase == OSR - 1);
    check("tready", int'(s_tready), int'(rdy));
    check("tvalid_out", int'(m_tvalid), int'(m_vld));
    check("underrun", int'(under), int'(m_under));
    s_tvalid = v;
    s_tdata  = W'(d);
    model_edge(v, d);
  endtask

  task automatic run_const(input int x, input int n,
                           input int win,
                           output int sum,
                           output int nz);
    sum = 0;
    nz  = 0;
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, x);
      if (i >= n - win) begin
        sum += int'(m_tdata);
        if (m_tdata != 0) nz++;
      end
    end
  endtask

  // Monitor: every presented output is matched against the scoreboard
  always @(negedge aclk) begin
    if (arst_n && m_tvalid) begin
      check("y_range",
            int'(m_tdata >= -3'sd1 && m_tdata <= 3'sd2), 1);
      if (exp_q.size() == 0) begin
        check("y_unexpected", int'(m_tdata), 99);
      end else begin
        check("y", int'(m_tdata), exp_q.pop_front());
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sum, nz, d;
    bit v;
    arst_n   = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    model_reset();
    repeat (3) @(negedge aclk);
    check("rst_tready", int'(s_tready), 1);
    check("rst_tvalid", int'(m_tvalid), 0);
    check("rst_tdata", int'(m_tdata), 0);
    check("rst_underrun", int'(under), 0);
    arst_n = 1'b1;

    run_const(0, OSR + 8 + 1024, 1024, sum, nz);
    check("mid_sum_ok",
          int'(sum >= 511 && sum <= 513), 1);

    run_const(-32768, OSR + 8 + 512, 512, sum, nz);
    check("negfs_nonzero", nz, 0);

    run_const(32767, OSR + 8 + 4096, 4096, sum, nz);
    check("posfs_sum_ok",
          int'(sum >= 4094 && sum <= 4098), 1);

    // exactly one boundary with no sample offered
    for (int i = 0; i < OSR; i++) cycle(1'b0, 1234);
    for (int i = 0; i < 2 * OSR; i++) cycle(1'b1, -20000);
    check("underrun_sticky", int'(under), 1);

    for (int i = 0; i < 20 * OSR; i++) begin
      v = ($urandom_range(0, 7) != 0);
      d = int'($urandom_range(0, 65535)) - 32768;
      cycle(v, d);
    end

    // asynchronous reset between edges
    @(posedge aclk);
    #3;
    arst_n = 1'b0;
    #1;
    check("arst_tready", int'(s_tready), 1);
    check("arst_tvalid", int'(m_tvalid), 0);
    check("arst_tdata", int'(m_tdata), 0);
    check("arst_underrun", int'(under), 0);
    s_tvalid = 1'b0;
    exp_q.delete();
    model_reset();
    @(negedge aclk);
    arst_n = 1'b1;

    for (int i = 0; i < 6 * OSR; i++) begin
      v = ($urandom_range(0, 15) != 0);
      d = int'($urandom_range(0, 65535)) - 32768;
      cycle(v, d);
    end

    @(negedge aclk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mash11_dsm.md
# mash11_dsm

Parametrised second-generation digital delta-sigma modulator for the DAC path. It implements a MASH 1-1 topology: two cascaded first-order error-feedback accumulators with digital noise cancellation, which gives second-order noise shaping and an unconditionally stable 3-level-plus output. It also adds an integrated zero-order-hold interpolator with an AXI-Stream input handshake, so upstream logic supplies one sample per OSR modulator cycles. It sits between the sample source / interpolation filter and the output driver.

## Interface
- WIDTH, 16: input sample width and accumulator width (≥ 4).
- OSR, 64: modulator cycles per input sample (≥ 2).
- aclk  in  1  clock; the modulator advances on every rising edge while running.
- arst_n  in  1  reset; asynchronous assert, active-low.
- s_axis_data_tdata  in  WIDTH  signed two's-complement input sample.
- s_axis_data_tvalid  in  1  input sample valid.
- s_axis_data_tready  out  1  input ready.
- m_axis_data_tdata  out  3  signed modulator output, range −1..+2.
- m_axis_data_tvalid  out  1  output valid, high every cycle while running.
- underrun  out  1  sticky flag; set when no sample is available at a hold boundary.

## Operation
- States:
  - IDLE (after reset): tready=1, tvalid_out=0, accumulators frozen at 0.
  - RUN: entered on the first accepted sample and never left except by reset.
- Input transfer: occurs on an edge with tvalid && tready and loads the hold register.
- Handshake timing:
  - In IDLE, tready is held at 1.
  - In RUN, tready=1 only in the cycle where the hold counter equals OSR−1; otherwise 0.
  - tready does not depend on tvalid.
- Hold counter:
  - Counts 0..OSR−1 in RUN and wraps to 0.
  - Cleared to 0 on entering RUN.
- Underrun: if tready=1 in RUN and tvalid=0, the hold register keeps the previous sample and `underrun` sets to 1. It clears only on reset, and the modulator keeps running.
- Offset mapping: u = hold ^ (1 << (WIDTH−1)), i.e. unsigned 0..2^WIDTH−1, so the output mean equals u / 2^WIDTH.
- Stage 1: s1 = acc1 + u (WIDTH+1 bits); c1 = s1[WIDTH]; acc1 ← s1[WIDTH−1:0].
- Stage 2: s2 = acc2 + acc1_next (WIDTH+1 bits); c2 = s2[WIDTH]; acc2 ← s2[WIDTH−1:0]; c2_z ← c2.
- Output: y = c1 + c2 − c2_z, signed 3-bit. This is the only legal set of values; −1..+2 by construction.
- Overflow: accumulator wrap-around is intentional and modular; there is no saturation anywhere.

## Timing
- Reset values: s_axis_data_tready=1, m_axis_data_tdata=0, m_axis_data_tvalid=0, underrun=0. Internal state also resets: acc1=acc2=c2_z=0, counter=0, hold=0.
- Reset mid-operation: all outputs return to reset values immediately (asynchronously) and the block returns to IDLE.
- Latency:
  - A sample accepted at edge k is in the hold register after edge k.
  - It contributes to acc/y computed at edge k+1.
  - It is visible on m_axis_data_tdata after edge k+1.
- First-sample valid: tvalid_out rises after edge k+1 for the first accepted sample and stays high.
- New-sample alignment: a new sample accepted at counter=OSR−1 takes effect exactly OSR cycles after the previous one. There are no gaps and no duplicated cycles.
- Output back-pressure: none. The consumer must take one output per cycle.

## Configuration
- DSM_DITHER_EN defined:
  - A 23-bit maximal-length LFSR (x^23+x^18+1, nonzero seed 1 at reset) advances every RUN cycle.
  - Its LSB is added as the carry-in of stage 1 (s1 = acc1 + u + d).
  - This breaks idle tones, at a mean bias of +0.5 LSB.
- DSM_DITHER_EN undefined: no LFSR; s1 = acc1 + u exactly. Output is bit-exact with the undithered reference model.

## Structure
- Shared package `dsm_pkg`:
  - output type `dsm_out_t` (logic signed [2:0]),
  - state enum {IDLE, RUN},
  - LFSR width/taps/seed constants.
- Sub-module `dsm_acc_stage`, instantiated twice:
  - WIDTH-bit accumulator with registered residue;
  - carry-out plus residue outputs;
  - enable and async reset.
- Top level holds:
  - handshake FSM,
  - hold counter and hold register,
  - noise-cancellation adder,
  - underrun flag,
  - optional LFSR.

## Test plan
- Reset behaviour: assert arst_n=0 mid-RUN asynchronously between edges → all outputs go to reset values without a clock edge; after release, tready=1 and tvalid_out=0.
- Mid-scale input: WIDTH=16, OSR=64, dither off, constant x=0x0000 → the sum of y over any aligned 1024 outputs after 4 cycles of settling is 512; y ∈ {−1..2} only.
- Negative full scale: x=−32768 → y=0 on every cycle.
- Positive full scale: x=+32767 → the sum over 65536 outputs is 65535 ±2.
- Handshake cadence: tvalid held high → tready pulses exactly once every 64 cycles, one accept per pulse, with no accept while tready=0.
- Underrun: drop tvalid for one boundary → underrun=1 from the next edge and stays set; y continues using the last sample; the next sample is accepted at the following boundary.
- Dither: with DSM_DITHER_EN and x=−32768 → y is nonzero in some cycles; the long-run mean is ≈ 2^−17 per cycle.
